// File: rtl/fetch_unit_if.sv
// Fetch-unit bus bundle: redirect input, instruction-memory request/response
// channel, and the instruction queue head toward decode.
interface fetch_unit_if;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        inst_valid;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        inst_ready;

    modport master (
        input  redirect_valid, redirect_pc,
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_resp_valid, imem_resp_data,
        output inst_valid, inst_data, inst_pc,
        input  inst_ready
    );

    modport slave (
        output redirect_valid, redirect_pc,
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_resp_valid, imem_resp_data,
        input  inst_valid, inst_data, inst_pc,
        output inst_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch unit: credit-limited in-order fetch into a registered queue,
// with redirect flushing and dropping of responses still in flight.
module fetch_unit_checker #(
    parameter int unsigned CW = 3
) (
    input logic          clk,
    input logic          reset,
    input logic          resp_valid,
    input logic [CW-1:0] out_cnt
);
    // A response with nothing outstanding is a memory-side protocol violation.
    a_resp_has_credit: assert property (@(posedge clk) disable iff (reset)
        resp_valid |-> (out_cnt != {CW{1'b0}}));
endmodule

module fetch_unit #(
    parameter int unsigned QUEUE_DEPTH = 4,
    parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
    input logic          clk,
    input logic          reset,
    fetch_unit_if.master bus
);
    localparam int unsigned AW  = $clog2(QUEUE_DEPTH);
    localparam int unsigned CW  = AW + 1;
    localparam int unsigned SW  = CW + 1;
    localparam logic [31:0] RESET_PC_W = RESET_PC & 32'hFFFF_FFFC;

    logic [31:0]   fetch_pc_r;
    logic [31:0]   ret_pc_r;
    logic [31:0]   data_mem_r [QUEUE_DEPTH];
    logic [31:0]   pc_mem_r   [QUEUE_DEPTH];
    logic [AW-1:0] head_r;
    logic [AW-1:0] tail_r;
    logic [CW-1:0] count_r;
    logic [CW-1:0] out_cnt_r;
    logic [CW-1:0] drop_cnt_r;
    logic          req_valid_r;
    logic          inst_valid_r;

    logic          accept_s;
    logic          resp_s;
    logic          pop_s;
    logic          push_s;
    logic [31:0]   fetch_pc_s;
    logic [31:0]   ret_pc_s;
    logic [AW-1:0] head_s;
    logic [AW-1:0] tail_s;
    logic [CW-1:0] count_s;
    logic [CW-1:0] out_cnt_s;
    logic [CW-1:0] drop_cnt_s;
    logic [SW-1:0] credit_s;

    // Next-state for pointers, counters and addresses; redirect overrides push/pop.
    always_comb begin
        accept_s  = req_valid_r && bus.imem_req_ready;
        resp_s    = bus.imem_resp_valid && (out_cnt_r != {CW{1'b0}});
        pop_s     = inst_valid_r && bus.inst_ready;
        out_cnt_s = out_cnt_r + CW'(accept_s) - CW'(resp_s);
        if (bus.redirect_valid) begin
            // Everything still owed by memory, including this cycle's request, is stale.
            push_s     = 1'b0;
            fetch_pc_s = bus.redirect_pc & 32'hFFFF_FFFC;
            ret_pc_s   = bus.redirect_pc & 32'hFFFF_FFFC;
            head_s     = {AW{1'b0}};
            tail_s     = {AW{1'b0}};
            count_s    = {CW{1'b0}};
            drop_cnt_s = out_cnt_s;
        end else begin
            push_s     = resp_s && (drop_cnt_r == {CW{1'b0}});
            fetch_pc_s = accept_s ? (fetch_pc_r + 32'd4) : fetch_pc_r;
            ret_pc_s   = push_s ? (ret_pc_r + 32'd4) : ret_pc_r;
            head_s     = pop_s ? (head_r + AW'(1'b1)) : head_r;
            tail_s     = push_s ? (tail_r + AW'(1'b1)) : tail_r;
            count_s    = count_r + CW'(push_s) - CW'(pop_s);
            drop_cnt_s = drop_cnt_r - CW'(resp_s && (drop_cnt_r != {CW{1'b0}}));
        end
        credit_s = SW'(count_s) + SW'(out_cnt_s);
    end

    // Control state and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_r   <= RESET_PC_W;
            ret_pc_r     <= RESET_PC_W;
            head_r       <= {AW{1'b0}};
            tail_r       <= {AW{1'b0}};
            count_r      <= {CW{1'b0}};
            out_cnt_r    <= {CW{1'b0}};
            drop_cnt_r   <= {CW{1'b0}};
            req_valid_r  <= 1'b0;
            inst_valid_r <= 1'b0;
        end else begin
            fetch_pc_r   <= fetch_pc_s;
            ret_pc_r     <= ret_pc_s;
            head_r       <= head_s;
            tail_r       <= tail_s;
            count_r      <= count_s;
            out_cnt_r    <= out_cnt_s;
            drop_cnt_r   <= drop_cnt_s;
            req_valid_r  <= (credit_s < SW'(QUEUE_DEPTH));
            inst_valid_r <= (count_s != {CW{1'b0}});
        end
    end

    // Queue storage; the credit limit keeps a push from landing on the live head.
    always_ff @(posedge clk) begin
        if (!reset && push_s) begin
            data_mem_r[tail_r] <= bus.imem_resp_data;
            pc_mem_r[tail_r]   <= ret_pc_r;
        end
    end

    assign bus.imem_req_valid = req_valid_r;
    assign bus.imem_req_addr  = fetch_pc_r;
    assign bus.inst_valid     = inst_valid_r;
    assign bus.inst_data      = data_mem_r[head_r];
    assign bus.inst_pc        = pc_mem_r[head_r];

    fetch_unit_checker #(.CW(CW)) u_checker (
        .clk        (clk),
        .reset      (reset),
        .resp_valid (bus.imem_resp_valid),
        .out_cnt    (out_cnt_r)
    );
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter QUEUE_DEPTH, default 4, which sets the instruction queue entries and the outstanding-request credit limit (power of 2, 2..16).
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000, which is the first fetch address after reset.
REQ-003 clk  input  1  clock; all state updates on posedge.
REQ-004 reset  input  1  synchronous, active-high.
REQ-005 redirect_valid  input  1  jump/branch/JR/JAL target from execute; one-cycle pulse.
REQ-006 redirect_pc  input  32  new fetch address.
REQ-007 imem_req_valid  output  1  fetch request valid.
REQ-008 imem_req_addr  output  32  byte address of fetched word.
REQ-009 imem_req_ready  input  1  memory accepts request.
REQ-010 imem_resp_valid  input  1  instruction word returned (in order, >=1 cycle after acceptance).
REQ-011 imem_resp_data  input  32  big-endian instruction word.
REQ-012 inst_valid  output  1  queue head valid toward decode/control.
REQ-013 inst_data  output  32  queue head instruction.
REQ-014 inst_pc  output  32  address of inst_data.
REQ-015 inst_ready  input  1  decode consumes head.

Function
REQ-016 A request SHALL be accepted in a cycle with imem_req_valid && imem_req_ready; fetch_pc SHALL then advance by 4, modulo 2^32.
REQ-017 imem_req_addr SHALL always equal fetch_pc, with bits [1:0] zero.
REQ-018 imem_req_valid SHALL be 1 iff not in reset and (queue occupancy + outstanding) < QUEUE_DEPTH.
REQ-019 Outstanding counter: +1 per accepted request, -1 per imem_resp_valid, both in the same cycle give net 0.
REQ-020 A non-dropped response SHALL be written to the queue tail with its PC; the tail PC comes from a separate retired-address register advanced by 4 per response.
REQ-021 Queue output SHALL be registered: a response in cycle N gives inst_valid=1 in N+1 at the earliest, with no bypass.
REQ-022 Head SHALL pop on inst_valid && inst_ready; simultaneous push and pop SHALL keep occupancy unchanged.
REQ-023 With the queue full and pop + push in the same cycle, the queue SHALL NOT lose data; the credit rule of REQ-018 guarantees the queue never overflows.
REQ-024 While a head is not popped, inst_data and inst_pc SHALL stay stable.
REQ-025 On redirect_valid in cycle N, in N+1:
- fetch_pc = {redirect_pc[31:2],2'b00};
- the retired-address register = the same value;
- the queue is empty;
- inst_valid=0.
REQ-026 On redirect in cycle N, drop_count SHALL load (outstanding + accepted_N - resp_N), and any response in cycle N SHALL be discarded.
REQ-027 While drop_count > 0, each response SHALL be discarded and drop_count decremented; dropped responses still decrement outstanding.
REQ-028 A redirect SHALL take priority over a simultaneous pop or push; a request accepted in cycle N uses the old address and is counted for dropping.
REQ-029 Back-to-back redirects SHALL be legal: the last redirect wins, and drop_count is recomputed each time.
REQ-030 imem_req_valid MAY assert in N+1 after a redirect, carrying the redirect address.
REQ-031 A response arriving with outstanding==0 is a protocol violation and SHALL be ignored; it is flagged by a simulation assertion.

Reset
REQ-032 While reset=1 at posedge:
- fetch_pc and the retired-address register = RESET_PC;
- queue empty;
- outstanding = 0 and drop_count = 0;
- imem_req_valid=0 and inst_valid=0.
REQ-033 Responses and redirects during reset SHALL be ignored.
REQ-034 Reset mid-operation SHALL discard all queued and in-flight words; the first request after reset deasserts SHALL use address RESET_PC.

Verification
REQ-035 Bench: reset; imem_req_ready=1; memory returns mem[a] 1 cycle later; inst_ready=1 -> inst_pc sequence 0,4,8,12 with inst_data matching mem[0..12], and one instruction per cycle in steady state.
REQ-036 Bench: inst_ready=0, memory always ready -> exactly 4 requests (0x0..0xC), then imem_req_valid=0; inst_valid held with inst_pc=0; raising inst_ready drains 0,4,8,C, then fetching resumes at 0x10.
REQ-037 Bench: 3-cycle memory latency, 3 requests in flight, redirect_pc=0x40 -> 3 responses dropped; next inst_pc=0x40, and 0x0..0x8 are never presented.
REQ-038 Bench: redirect_pc=0x42 -> request address 0x40 and inst_pc=0x40.
REQ-039 Bench: redirect coincident with a response and a pop -> the queue is empty next cycle, and drop_count equals the in-flight count.
REQ-040 Bench: fetch_pc=0xFFFF_FFFC -> the next request address is 0x0000_0000; and assert reset with 2 requests outstanding -> their later responses are ignored, and the first post-reset request is at RESET_PC.
